// File: rtl/issue_select_pkg.sv
// Shared types for the issue selector: reservation-buffer entry, issue payload
// and the enums both carry.
package issue_select_pkg;

  localparam int BUF_SIZE     = 16;
  localparam int BUF_SIZE_LOG = $clog2(BUF_SIZE);
  localparam int TAG_W        = BUF_SIZE_LOG + 1;
  localparam int SPEC_W       = 6;
  localparam int OP_W         = 5;
  localparam int XLEN         = 32;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    BRANCH = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    MUL    = 3'd4,
    DIV    = 3'd5
  } unit_t;

  typedef enum logic [2:0] {
    S_EMPTY          = 3'd0,
    S_NOT_EXECUTED   = 3'd1,
    S_ADDR_GENERATED = 3'd2,
    S_EXECUTED       = 3'd3,
    S_COMPLETED      = 3'd4
  } e_state_t;

  typedef enum logic {
    EX_NORMAL   = 1'b0,
    EX_GEN_ADDR = 1'b1
  } ex_mode_t;

  typedef enum logic [1:0] {
    LDST_BYTE = 2'd0,
    LDST_HALF = 2'd1,
    LDST_WORD = 2'd2
  } ldst_mode_t;

  typedef struct packed {
    e_state_t          e_state;
    logic [TAG_W-1:0]  tag;
    unit_t             unit;
    logic [OP_W-1:0]   op;
    ldst_mode_t        ldst;
    logic [2:0]        rwmm;
    logic [SPEC_W-1:0] specific_speculative_tag;
    logic              J_rdy;
    logic              K_rdy;
    logic              A_rdy;
    logic [3:0]        number_of_early_store_ops;
    logic [XLEN-1:0]   Vj;
    logic [XLEN-1:0]   Vk;
    logic [XLEN-1:0]   A;
    logic [XLEN-1:0]   pc;
  } entry_t;

  typedef struct packed {
    logic              is_valid;
    ex_mode_t          mode;
    unit_t             unit;
    logic [OP_W-1:0]   op;
    ldst_mode_t        ldst;
    logic [2:0]        rm;
    logic [SPEC_W-1:0] speculative_tag;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   Vj;
    logic [XLEN-1:0]   Vk;
    logic [XLEN-1:0]   A;
    logic [XLEN-1:0]   pc;
  } ex_content_t;

endpackage

// File: rtl/issue_pick_one.sv
// Picks the highest-tag eligible, non-excluded entry that this port may carry.
module issue_pick_one
  import issue_select_pkg::*;
(
  input  entry_t                  entries [BUF_SIZE],
  input  logic [BUF_SIZE-1:0]     excl,
  input  logic                    mem_ok,
  output logic                    valid,
  output logic [BUF_SIZE_LOG-1:0] idx,
  output entry_t                  pick
);

  logic [BUF_SIZE-1:0] cand;
  logic [TAG_W-1:0]    best_tag;

  always_comb begin
    cand = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      // Address-ready memory ops execute for real and need a memory port.
      cand[i] = entries[i].J_rdy && entries[i].K_rdy
             && (entries[i].e_state == S_NOT_EXECUTED ||
                 entries[i].e_state == S_ADDR_GENERATED)
             && (entries[i].unit != LOAD || entries[i].number_of_early_store_ops == 4'd0)
             && !excl[i]
             && (mem_ok || !entries[i].A_rdy ||
                 (entries[i].unit != LOAD && entries[i].unit != STORE));
    end
  end

  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    best_tag = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (cand[i] && (!valid || entries[i].tag > best_tag)) begin
        valid    = 1'b1;
        idx      = BUF_SIZE_LOG'(i);
        best_tag = entries[i].tag;
      end
    end
    pick = entries[idx];
  end

endmodule

// File: rtl/issue_select.sv
// Multi-port issue selector: chained per-port picks, registered ex_content
// slots with valid/ready handshake and misprediction flush.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int ISSUE_W   = 2,
  parameter int MEM_PORTS = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              is_tag_flooded,
  input  entry_t                            entries [BUF_SIZE],
  input  logic                              flush_valid,
  input  logic [SPEC_W-1:0]                 flush_tag_mask,
  input  logic [ISSUE_W-1:0]                issue_ready,
  output ex_content_t                       ex_contents [ISSUE_W],
  output logic [ISSUE_W-1:0][BUF_SIZE-1:0]  grant
);

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_port
    localparam logic MEM_OK = (gi < MEM_PORTS);

    logic [BUF_SIZE-1:0]     excl_in;
    logic [BUF_SIZE-1:0]     excl_out;
    logic [BUF_SIZE-1:0]     onehot;
    logic                    free;
    logic                    take;
    logic                    pick_valid;
    logic [BUF_SIZE_LOG-1:0] pick_idx;
    entry_t                  pick;
    ex_content_t             fmt;
    ex_content_t             ex_d;
    ex_content_t             ex_q;
    logic                    unused_pick;

    // Lower ports claim first; a busy port passes the mask through untouched.
    if (gi == 0) begin : g_first
      assign excl_in = '0;
    end else begin : g_chain
      assign excl_in = g_port[gi-1].excl_out;
    end

    issue_pick_one u_pick (
      .entries (entries),
      .excl    (excl_in),
      .mem_ok  (MEM_OK),
      .valid   (pick_valid),
      .idx     (pick_idx),
      .pick    (pick)
    );

    assign free     = !ex_q.is_valid || issue_ready[gi];
    assign take     = rst_n && free && !flush_valid && pick_valid;
    assign onehot   = take ? (BUF_SIZE'(1) << pick_idx) : '0;
    assign excl_out = excl_in | onehot;
    assign grant[gi] = onehot;

    always_comb begin
      fmt                 = '0;
      fmt.is_valid        = 1'b1;
      fmt.mode            = pick.A_rdy ? EX_NORMAL : EX_GEN_ADDR;
      fmt.unit            = pick.A_rdy ? pick.unit : ALU;
      fmt.op              = pick.A_rdy ? pick.op : '0;
      fmt.ldst            = pick.ldst;
      fmt.rm              = pick.rwmm;
      fmt.speculative_tag = pick.specific_speculative_tag;
      fmt.tag             = is_tag_flooded ? {1'b1, pick.tag[BUF_SIZE_LOG-1:0]} : pick.tag;
      fmt.Vj              = pick.Vj;
      fmt.Vk              = pick.A_rdy ? pick.Vk : pick.A;
      fmt.A               = pick.A;
      fmt.pc              = pick.pc;
    end

    assign unused_pick = ^{pick.e_state, pick.J_rdy, pick.K_rdy,
                           pick.number_of_early_store_ops};

    always_comb begin
      ex_d = ex_q;
      if (flush_valid) begin
        // Killed or consumed slots empty out; nothing new loads during a flush.
        if ((ex_q.speculative_tag & flush_tag_mask) != '0 || issue_ready[gi]) begin
          ex_d.is_valid = 1'b0;
        end
      end else if (free) begin
        if (pick_valid) begin
          ex_d = fmt;
        end else begin
          ex_d.is_valid = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ex_q <= '0;
      end else begin
        ex_q <= ex_d;
      end
    end

    assign ex_contents[gi] = ex_q;
  end

endmodule

// File: tb/tb_issue_select.sv
// Table-driven bench for issue_select with a scoreboard of expected slot contents.
`timescale 1ns/1ps
module tb_issue_select;
  import issue_select_pkg::*;

  localparam int ISSUE_W   = 2;
  localparam int MEM_PORTS = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic is_tag_flooded = 1'b0;
  logic flush_valid = 1'b0;
  logic [SPEC_W-1:0] flush_tag_mask = '0;
  logic [ISSUE_W-1:0] issue_ready = '0;
  entry_t entries [BUF_SIZE];
  ex_content_t ex_contents [ISSUE_W];
  logic [ISSUE_W-1:0][BUF_SIZE-1:0] grant;

  issue_select #(.ISSUE_W(ISSUE_W), .MEM_PORTS(MEM_PORTS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .is_tag_flooded (is_tag_flooded),
    .entries        (entries),
    .flush_valid    (flush_valid),
    .flush_tag_mask (flush_tag_mask),
    .issue_ready    (issue_ready),
    .ex_contents    (ex_contents),
    .grant          (grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
    logic [4:0] tag;
    unit_t      u;
    logic       ardy;
    logic [5:0] spec;
  } desc_t;

  typedef struct packed {
    desc_t [2:0] e;
    logic [1:0]  rdy;
    logic        fl;
    logic [5:0]  fmask;
    logic        flood;
    logic [15:0] g0;
    logic [15:0] g1;
    logic        v0;
    logic [4:0]  t0;
    logic        v1;
    logic [4:0]  t1;
  } vec_t;

  typedef struct packed {
    logic       port;
    logic       v;
    logic [4:0] t;
  } sb_t;

  vec_t vecs [15];
  sb_t  sbq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_ex(input string name, input ex_content_t act, input ex_content_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic desc_t d(input int idx, input int tag, input unit_t u,
                              input logic ardy, input logic [5:0] spec);
    desc_t r;
    r.en = 1'b1; r.idx = 4'(idx); r.tag = 5'(tag); r.u = u; r.ardy = ardy; r.spec = spec;
    return r;
  endfunction

  function automatic vec_t mk(input desc_t a, input desc_t b, input desc_t c,
                              input logic [1:0] rdy, input logic fl, input logic [5:0] fmask,
                              input logic flood, input logic [15:0] g0, input logic [15:0] g1,
                              input logic v0, input int t0, input logic v1, input int t1);
    vec_t r;
    r.e[0] = a; r.e[1] = b; r.e[2] = c;
    r.rdy = rdy; r.fl = fl; r.fmask = fmask; r.flood = flood;
    r.g0 = g0; r.g1 = g1; r.v0 = v0; r.t0 = 5'(t0); r.v1 = v1; r.t1 = 5'(t1);
    return r;
  endfunction

  // Payload the bench expects for an entry built by put().
  function automatic ex_content_t exp_fmt(input int idx, input int tag, input unit_t u,
                                          input logic ardy, input logic [5:0] spec,
                                          input logic flood);
    ex_content_t e;
    logic [4:0] t;
    t = 5'(tag);
    e = '0;
    e.is_valid = 1'b1;
    e.mode = ardy ? EX_NORMAL : EX_GEN_ADDR;
    e.unit = ardy ? u : ALU;
    e.op = ardy ? 5'(idx + 1) : 5'd0;
    e.ldst = LDST_BYTE;
    e.rm = 3'd2;
    e.speculative_tag = spec;
    e.tag = flood ? {1'b1, t[3:0]} : t;
    e.Vj = 32'h1000 + 32'(idx);
    e.Vk = ardy ? 32'hB000 + 32'(idx) : 32'hA000 + 32'(idx);
    e.A = 32'hA000 + 32'(idx);
    e.pc = 32'h4000 + 32'(idx * 4);
    return e;
  endfunction

  task automatic clear_buf();
    for (int i = 0; i < BUF_SIZE; i++) entries[i] = '0;
  endtask

  task automatic put(input desc_t x);
    entry_t e;
    e = '0;
    e.e_state = S_NOT_EXECUTED;
    e.tag = x.tag;
    e.unit = x.u;
    e.op = 5'(int'(x.idx) + 1);
    e.ldst = LDST_BYTE;
    e.rwmm = 3'd2;
    e.specific_speculative_tag = x.spec;
    e.J_rdy = 1'b1;
    e.K_rdy = 1'b1;
    e.A_rdy = x.ardy;
    e.Vj = 32'h1000 + 32'(x.idx);
    e.Vk = 32'hB000 + 32'(x.idx);
    e.A = 32'hA000 + 32'(x.idx);
    e.pc = 32'h4000 + 32'(int'(x.idx) * 4);
    entries[x.idx] = e;
  endtask

  task automatic run_rows(input int lo, input int hi);
    sb_t s;
    for (int r = lo; r <= hi; r++) begin
      @(negedge clk);
      clear_buf();
      for (int k = 0; k < 3; k++) if (vecs[r].e[k].en) put(vecs[r].e[k]);
      issue_ready = vecs[r].rdy;
      flush_valid = vecs[r].fl;
      flush_tag_mask = vecs[r].fmask;
      is_tag_flooded = vecs[r].flood;
      #2;
      check($sformatf("row%0d grant0", r), 64'(grant[0]), 64'(vecs[r].g0));
      check($sformatf("row%0d grant1", r), 64'(grant[1]), 64'(vecs[r].g1));
      sbq.push_back('{port: 1'b0, v: vecs[r].v0, t: vecs[r].t0});
      sbq.push_back('{port: 1'b1, v: vecs[r].v1, t: vecs[r].t1});
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
        s = sbq.pop_front();
        check($sformatf("row%0d p%0d valid", r, s.port), 64'(ex_contents[s.port].is_valid), 64'(s.v));
        if (s.v) check($sformatf("row%0d p%0d tag", r, s.port), 64'(ex_contents[s.port].tag), 64'(s.t));
      end
      $display("row %0d: grant=%h p0 v=%0b t=%0d p1 v=%0b t=%0d", r, grant,
               ex_contents[0].is_valid, ex_contents[0].tag,
               ex_contents[1].is_valid, ex_contents[1].tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t none;
    none = '0;
    vecs[0]  = mk(d(2,3,ALU,1,0), d(5,9,ALU,1,0), d(11,5,ALU,1,0), 2'b11, 0, 0, 0, 16'h0020, 16'h0800, 1, 9, 1, 5);
    vecs[1]  = mk(d(2,3,ALU,1,0), d(7,12,ALU,1,0), none,           2'b11, 0, 0, 0, 16'h0080, 16'h0004, 1, 12, 1, 3);
    vecs[2]  = mk(d(1,7,LOAD,1,0), d(4,4,ALU,1,0), none,           2'b10, 0, 0, 0, 16'h0000, 16'h0010, 1, 12, 1, 4);
    vecs[3]  = mk(d(1,7,LOAD,1,0), none, none,                     2'b01, 0, 0, 0, 16'h0002, 16'h0000, 1, 7, 1, 4);
    vecs[4]  = mk(d(1,7,LOAD,1,0), none, none,                     2'b10, 0, 0, 0, 16'h0000, 16'h0000, 1, 7, 0, 0);
    vecs[5]  = mk(d(1,7,LOAD,0,0), none, none,                     2'b10, 0, 0, 0, 16'h0000, 16'h0002, 1, 7, 1, 7);
    vecs[6]  = mk(d(3,2,ALU,1,0), none, none,                      2'b00, 0, 0, 0, 16'h0000, 16'h0000, 1, 7, 1, 7);
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = mk(d(3,2,ALU,1,0), none, none,                      2'b01, 0, 0, 0, 16'h0008, 16'h0000, 1, 2, 1, 7);
    vecs[10] = mk(d(6,10,ALU,1,6'b000010), d(8,11,ALU,1,6'b000100), none, 2'b11, 0, 0, 0, 16'h0100, 16'h0040, 1, 11, 1, 10);
    vecs[11] = mk(d(9,1,ALU,1,0), none, none,                      2'b00, 1, 6'b000010, 0, 16'h0000, 16'h0000, 1, 11, 0, 0);
    vecs[12] = mk(d(9,1,ALU,1,0), none, none,                      2'b01, 1, 6'b000100, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    vecs[13] = mk(d(3,3,ALU,1,0), none, none,                      2'b00, 0, 0, 1, 16'h0008, 16'h0000, 1, 19, 0, 0);
    vecs[14] = mk(none, none, none,                                2'b11, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Reset state with an eligible entry present: no grant, slots cleared.
    clear_buf();
    put(d(4,6,ALU,1,0));
    repeat (2) @(posedge clk);
    #1;
    check_ex("reset p0", ex_contents[0], '0);
    check_ex("reset p1", ex_contents[1], '0);
    check("reset grant", 64'(grant), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_rows(0, 5);
    check_ex("normal load p0", ex_contents[0], exp_fmt(1, 7, LOAD, 1'b1, 6'd0, 1'b0));
    check_ex("gen_addr p1", ex_contents[1], exp_fmt(1, 7, LOAD, 1'b0, 6'd0, 1'b0));
    for (int r = 6; r <= 8; r++) begin
      run_rows(r, r);
      check_ex($sformatf("stall%0d p0", r), ex_contents[0], exp_fmt(1, 7, LOAD, 1'b1, 6'd0, 1'b0));
    end
    run_rows(9, 13);
    check_ex("flooded p0", ex_contents[0], exp_fmt(3, 3, ALU, 1'b1, 6'd0, 1'b1));
    run_rows(14, 14);

    // Mid-operation asynchronous reset, then first grant after release.
    @(negedge clk);
    clear_buf();
    put(d(4,6,ALU,1,0));
    put(d(10,8,ALU,1,0));
    issue_ready = 2'b00;
    @(posedge clk);
    #1;
    check("pre-reset p0 valid", 64'(ex_contents[0].is_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_ex("async reset p0", ex_contents[0], '0);
    check_ex("async reset p1", ex_contents[1], '0);
    check("async reset grant", 64'(grant), 64'd0);
    @(posedge clk);
    #1;
    check("held reset p0 valid", 64'(ex_contents[0].is_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release grant0", 64'(grant[0]), 64'h0400);
    check("release grant1", 64'(grant[1]), 64'h0010);
    @(posedge clk);
    #1;
    check("release p0 tag", 64'(ex_contents[0].tag), 64'd8);
    check("release p1 tag", 64'(ex_contents[1].tag), 64'd6);
    $display("reset seq: p0 t=%0d p1 t=%0d", ex_contents[0].tag, ex_contents[1].tag);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/issue_select.md
# issue_select

Registered multi-port issue selector for the out-of-order backend. Each cycle it picks up to ISSUE_W ready, not-yet-executed reservation-buffer entries in tag-priority order and grants them back to the buffer so their state can advance. It steers memory ops to the memory-capable ports, builds one `ex_content` per port and holds it in a per-port output register under a valid/ready handshake. Sits between the reservation buffer and the execute units. Supports branch-misprediction flush of held slots.

## Interface
- `BUF_SIZE`, default 16: entries in the reservation buffer; `BUF_SIZE_LOG` = $clog2(BUF_SIZE).
- `ISSUE_W`, default 2: number of issue ports, 1..4.
- `MEM_PORTS`, default 1: ports 0..MEM_PORTS-1 may carry LOAD/STORE in EX_NORMAL mode; 1..ISSUE_W.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `is_tag_flooded`  in  1  forces MSB of issued tag to 1.
- `entries`  in  entry[BUF_SIZE]  current buffer contents.
- `flush_valid`  in  1  misprediction flush this cycle.
- `flush_tag_mask`  in  6  speculative-tag bits being killed.
- `issue_ready`  in  ISSUE_W  execute unit p accepts slot p this cycle.
- `ex_contents`  out  ex_content[ISSUE_W]  registered issue payload; `.is_valid` is the per-port valid.
- `grant`  out  ISSUE_W x BUF_SIZE  combinational one-hot entry grant per port; the buffer marks the granted entry issued at the same edge.

## Operation
- Eligible entry: J_rdy && K_rdy && e_state ∈ {S_NOT_EXECUTED, S_ADDR_GENERATED} && (Unit != LOAD || number_of_early_store_ops == 0).
- Mode per entry: A_rdy → EX_NORMAL, Unit/Op/Vk from entry. !A_rdy → EX_GEN_ADDR, Unit=ALU, Op=0, Vk=A. Other fields: rm=rwmm, speculative_tag=specific_speculative_tag, Vj, A, pc copied.
- Tag out: is_tag_flooded ? {1'b1, tag[BUF_SIZE_LOG-1:0]} : tag.
- Port p is free if !ex_contents[p].is_valid || issue_ready[p].
- Selection: free ports are filled in ascending port order. Each port takes the highest-tag eligible entry not already granted to a lower port this cycle that the port may carry. An EX_NORMAL LOAD/STORE is carryable only on p < MEM_PORTS. EX_GEN_ADDR and non-memory units may use any port. Ties are impossible because tags are unique.
- No eligible candidate for a free port: grant[p]=0, and the slot loads is_valid=0 if it was consumed.
- Busy (non-free) port: grant[p]=0, content held bit-stable.
- Flush cycle (flush_valid=1): all grants 0, no new loads. Any held slot with (speculative_tag & flush_tag_mask) != 0 clears is_valid at the edge. Surviving slots behave as busy/consumed normally.
- An entry is never granted twice: the grant and the buffer's state update share the same edge.

## Timing
- Reset (rst_n=0, async): every ex_contents field 0, is_valid 0. grant is 0 while in reset.
- Latency: entry eligible in cycle N → grant in N (comb) → ex_contents valid from N+1.
- Handshake: valid && ready at edge = transfer. The slot may reload in the same cycle, giving back-to-back issue at full rate. Valid never drops without a transfer or a flush.
- Reset mid-operation: held slots are discarded; no grant is emitted while rst_n=0.
- Selection is a ISSUE_W-deep priority chain over BUF_SIZE and may be the critical path. Output is registered, so downstream sees no comb path from `entries`.

## Structure
- Shared package: `entry`, `ex_content`, `unit`, `ex_mode`, `ldst_mode`, e_state enum, BUF_SIZE/BUF_SIZE_LOG. Extend `ex_content` there, not locally.
- Sub-module `issue_pick_one`: it takes entries, an exclusion mask and a mem_ok flag, and returns valid, index and entry. It is instantiated once per port and chained through the exclusion masks.
- The top holds per-port output registers, flush kill logic and ex_content formatting.

## Test plan
- Reset: assert rst_n=0 mid-stream with slots valid → all is_valid=0 and fields 0 immediately. First grant appears the cycle after release.
- Priority: eligible tags 3, 9, 5, ISSUE_W=2, ready=11 → port0 gets tag 9, port1 gets tag 5 next cycle; grant one-hots match the entry indices.
- Steering: only eligible entries are LOAD tag 7 (A_rdy=1) and ALU tag 4, MEM_PORTS=1, port0 busy → port1 takes tag 4 and the load waits. Once port0 frees, the load issues on port0. Same load with A_rdy=0 → EX_GEN_ADDR, Unit=ALU, Vk=A, any port.
- Backpressure: issue_ready[0]=0 for 3 cycles → port0 content bit-stable and grant[0]=0. The ready pulse transfers, and a new entry loads the same cycle.
- Flush: slots hold spec tags 6'b000010 and 6'b000100, flush_tag_mask=6'b000010 → first slot invalid next cycle, second kept, no grants in the flush cycle.
- Flooded: is_tag_flooded=1 with entry tag 0b00011 (BUF_SIZE=16) → issued tag 0b10011.
